// File: rtl/time_set_ctrl_if.sv
// Button, counter-value and load/display signals of the clock time-set controller.
// master = controller side, slave = counter/display/button side.
interface time_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hour_in;
    logic [5:0] min_in;
    logic [5:0] sec_in;
    logic       sec_tick;
    logic       load_hour;
    logic       load_min;
    logic       load_sec;
    logic [5:0] load_data;
    logic [1:0] edit_field;
    logic       blink;

    modport master (
        input  btn_mode, btn_inc, hour_in, min_in, sec_in,
        output sec_tick, load_hour, load_min, load_sec,
        output load_data, edit_field, blink
    );

    modport slave (
        output btn_mode, btn_inc, hour_in, min_in, sec_in,
        input  sec_tick, load_hour, load_min, load_sec,
        input  load_data, edit_field, blink
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Digital clock sequencer: 1 Hz tick prescaler plus time-set FSM with shadow registers.
// Optional button auto-repeat is enabled by defining AUTO_REPEAT_EN.
module time_set_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 10_000_000
) (
    input  logic             clk,
    input  logic             clear_n,
    time_set_ctrl_if.master  bus
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);

    typedef enum logic [2:0] {
        RUN,
        SET_HOUR,
        SET_MIN,
        SET_SEC,
        CMT_H,
        CMT_M,
        CMT_S
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    sh_hour_q, sh_hour_d;
    logic [5:0]    sh_min_q, sh_min_d;
    logic [5:0]    sh_sec_q, sh_sec_d;
    logic [2:0]    mode_sync_q;
    logic [2:0]    inc_sync_q;

    logic          tick_q, tick_d;
    logic          ld_h_q, ld_h_d;
    logic          ld_m_q, ld_m_d;
    logic          ld_s_q, ld_s_d;
    logic [5:0]    data_q, data_d;
    logic [1:0]    ef_q, ef_d;
    logic          blink_q, blink_d;

    logic          mode_ev;
    logic          inc_ev;
    logic          rep_ev;
    logic          inc_any;

    // [0],[1] synchronise; [2] holds the previous synchronised level
    assign mode_ev = mode_sync_q[1] & ~mode_sync_q[2];
    assign inc_ev  = inc_sync_q[1] & ~inc_sync_q[2];
    assign inc_any = inc_ev | rep_ev;

`ifdef AUTO_REPEAT_EN
    localparam int HMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int HW = $clog2(HMAX + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          armed_q, armed_d;
    logic          in_set;

    assign in_set = (state_q == SET_HOUR) ||
                    (state_q == SET_MIN) ||
                    (state_q == SET_SEC);

    // First repeat after REPEAT_DLY held cycles, then one per REPEAT_PER
    always_comb begin
        hold_d  = '0;
        armed_d = 1'b0;
        rep_ev  = 1'b0;
        if (in_set && inc_sync_q[1] && !mode_ev) begin
            hold_d  = hold_q + 1'b1;
            armed_d = armed_q;
            if (!armed_q && hold_d == HW'(REPEAT_DLY)) begin
                rep_ev  = 1'b1;
                armed_d = 1'b1;
                hold_d  = '0;
            end else if (armed_q && hold_d == HW'(REPEAT_PER)) begin
                rep_ev = 1'b1;
                hold_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            hold_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            armed_q <= armed_d;
        end
    end
`else
    logic unused_rep;

    assign rep_ev = 1'b0;
    assign unused_rep = REPEAT_DLY[0] ^ REPEAT_PER[0];
`endif

    always_comb begin
        state_d  = state_q;
        sh_hour_d = sh_hour_q;
        sh_min_d  = sh_min_q;
        sh_sec_d  = sh_sec_q;
        if (state_q == CMT_S || cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            RUN: begin
                if (mode_ev) begin
                    state_d   = SET_HOUR;
                    sh_hour_d = bus.hour_in;
                    sh_min_d  = bus.min_in;
                    sh_sec_d  = bus.sec_in;
                end
            end
            SET_HOUR: begin
                if (mode_ev) begin
                    state_d = SET_MIN;
                end else if (inc_any) begin
                    sh_hour_d = (sh_hour_q == 5'd23) ? 5'd0 : sh_hour_q + 5'd1;
                end
            end
            SET_MIN: begin
                if (mode_ev) begin
                    state_d = SET_SEC;
                end else if (inc_any) begin
                    sh_min_d = (sh_min_q == 6'd59) ? 6'd0 : sh_min_q + 6'd1;
                end
            end
            SET_SEC: begin
                if (mode_ev) begin
                    state_d = CMT_H;
                end else if (inc_any) begin
                    sh_sec_d = (sh_sec_q == 6'd59) ? 6'd0 : sh_sec_q + 6'd1;
                end
            end
            CMT_H:   state_d = CMT_M;
            CMT_M:   state_d = CMT_S;
            CMT_S:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state
    always_comb begin
        tick_d  = (state_d == RUN) && (cnt_d == CNT_MAX);
        ld_h_d  = 1'b0;
        ld_m_d  = 1'b0;
        ld_s_d  = 1'b0;
        data_d  = '0;
        ef_d    = 2'd0;
        blink_d = 1'b0;
        unique case (1'b1)
            (state_d == CMT_H): begin
                ld_h_d = 1'b1;
                data_d = {1'b0, sh_hour_d};
            end
            (state_d == CMT_M): begin
                ld_m_d = 1'b1;
                data_d = sh_min_d;
            end
            (state_d == CMT_S): begin
                ld_s_d = 1'b1;
                data_d = sh_sec_d;
            end
            (state_d == SET_HOUR): begin
                ef_d    = 2'd1;
                blink_d = (cnt_d < CNT_HALF);
            end
            (state_d == SET_MIN): begin
                ef_d    = 2'd2;
                blink_d = (cnt_d < CNT_HALF);
            end
            (state_d == SET_SEC): begin
                ef_d    = 2'd3;
                blink_d = (cnt_d < CNT_HALF);
            end
            default: begin
                ef_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            sh_hour_q   <= '0;
            sh_min_q    <= '0;
            sh_sec_q    <= '0;
            mode_sync_q <= '0;
            inc_sync_q  <= '0;
            tick_q      <= 1'b0;
            ld_h_q      <= 1'b0;
            ld_m_q      <= 1'b0;
            ld_s_q      <= 1'b0;
            data_q      <= '0;
            ef_q        <= 2'd0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_hour_q   <= sh_hour_d;
            sh_min_q    <= sh_min_d;
            sh_sec_q    <= sh_sec_d;
            mode_sync_q <= {mode_sync_q[1:0], bus.btn_mode};
            inc_sync_q  <= {inc_sync_q[1:0], bus.btn_inc};
            tick_q      <= tick_d;
            ld_h_q      <= ld_h_d;
            ld_m_q      <= ld_m_d;
            ld_s_q      <= ld_s_d;
            data_q      <= data_d;
            ef_q        <= ef_d;
            blink_q     <= blink_d;
        end
    end

    assign bus.sec_tick   = tick_q;
    assign bus.load_hour  = ld_h_q;
    assign bus.load_min   = ld_m_q;
    assign bus.load_sec   = ld_s_q;
    assign bus.load_data  = data_q;
    assign bus.edit_field = ef_q;
    assign bus.blink      = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios then random buttons/reset,
// every cycle compared against a cycle-level reference model of the clock controller.
module tb_time_set_ctrl;

    localparam int TD = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic clear_n = 1'b0;

    always #5 clk = ~clk;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .TICK_DIV  (TD),
        .REPEAT_DLY(RD),
        .REPEAT_PER(RP)
    ) dut (
        .clk    (clk),
        .clear_n(clear_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_i = 0;

    // Reference model: 0=run 1..3=editing h/m/s 4..6=committing h/m/s
    int ms, mpc, sh_h, sh_m, sh_s;
    bit bm1, bm2, bm3, bi1, bi2, bi3;
`ifdef AUTO_REPEAT_EN
    int hold;
`endif

    int tick_q[$];
    int lg_kind[$];
    int lg_data[$];
    int lg_cyc[$];

    always @(posedge clk or negedge clear_n) begin : model
        bit evm, evi, rep;
        int nms, nh, nm, ns;
        if (!clear_n) begin
            ms <= 0; mpc <= 0;
            sh_h <= 0; sh_m <= 0; sh_s <= 0;
            bm1 <= 0; bm2 <= 0; bm3 <= 0;
            bi1 <= 0; bi2 <= 0; bi3 <= 0;
`ifdef AUTO_REPEAT_EN
            hold <= 0;
`endif
        end else begin
            // a press is seen on the third edge after the button rises
            evm = bm2 && !bm3;
            evi = bi2 && !bi3;
            rep = 1'b0;
`ifdef AUTO_REPEAT_EN
            if (ms >= 1 && ms <= 3 && bi2 && !evm) begin
                hold <= hold + 1;
                rep = (hold + 1 == RD) ||
                      (hold + 1 > RD && (hold + 1 - RD) % RP == 0);
            end else begin
                hold <= 0;
            end
`endif
            nms = ms; nh = sh_h; nm = sh_m; ns = sh_s;
            case (ms)
                0: if (evm) begin
                    nms = 1;
                    nh = bus.hour_in; nm = bus.min_in; ns = bus.sec_in;
                end
                1, 2, 3: begin
                    if (evm) nms = ms + 1;
                    else if (evi || rep) begin
                        if (ms == 1) nh = (sh_h + 1) % 24;
                        if (ms == 2) nm = (sh_m + 1) % 60;
                        if (ms == 3) ns = (sh_s + 1) % 60;
                    end
                end
                4, 5: nms = ms + 1;
                default: nms = 0;
            endcase
            mpc <= (ms == 6) ? 0 : (mpc + 1) % TD;
            ms <= nms; sh_h <= nh; sh_m <= nm; sh_s <= ns;
            bm1 <= bus.btn_mode; bm2 <= bm1; bm3 <= bm2;
            bi1 <= bus.btn_inc; bi2 <= bi1; bi3 <= bi2;
        end
    end

    task automatic chk(string tag, int got, int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int eff, bl, dat;
        eff = (ms >= 1 && ms <= 3) ? ms : 0;
        bl = (ms >= 1 && ms <= 3 && mpc < TD / 2) ? 1 : 0;
        dat = (ms == 4) ? sh_h : (ms == 5) ? sh_m : (ms == 6) ? sh_s : 0;
        chk("sec_tick", bus.sec_tick, (ms == 0 && mpc == TD - 1) ? 1 : 0);
        chk("load_hour", bus.load_hour, (ms == 4) ? 1 : 0);
        chk("load_min", bus.load_min, (ms == 5) ? 1 : 0);
        chk("load_sec", bus.load_sec, (ms == 6) ? 1 : 0);
        chk("load_data", bus.load_data, dat);
        chk("edit_field", bus.edit_field, eff);
        chk("blink", bus.blink, bl);
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc_i++;
            check_all();
            if (bus.sec_tick) tick_q.push_back(cyc_i);
            if (bus.load_hour || bus.load_min || bus.load_sec) begin
                lg_kind.push_back(bus.load_hour ? 1 : bus.load_min ? 2 : 3);
                lg_data.push_back(bus.load_data);
                lg_cyc.push_back(cyc_i);
            end
        end
    endtask

    task automatic press(bit m, bit i);
        bus.btn_mode = m;
        bus.btn_inc = i;
        cyc(2);
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        cyc(3);
    endtask

    task automatic clr_logs();
        tick_q.delete();
        lg_kind.delete();
        lg_data.delete();
        lg_cyc.delete();
    endtask

    task automatic set_in(int h, int m, int s);
        bus.hour_in = 5'(h);
        bus.min_in = 6'(m);
        bus.sec_in = 6'(s);
    endtask

    initial begin
        int t0, n_set, first, seen;
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        set_in(0, 0, 0);

        // reset state
        cyc(3);
        chk("rst_zero", {bus.sec_tick, bus.load_hour, bus.load_min,
            bus.load_sec, bus.load_data, bus.edit_field, bus.blink}, 0);

        // idle after reset: tick every TD cycles, no loads
        clear_n = 1'b1;
        clr_logs();
        t0 = cyc_i;
        cyc(40);
        chk("t1_nticks", tick_q.size(), 5);
        if (tick_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("t1_tick_pos", tick_q[i] - t0, 8 * i + 7);
        end
        chk("t1_loads", lg_kind.size(), 0);

        // edit with wraps, then commit
        set_in(22, 59, 10);
        press(1, 0);
        clr_logs();
        repeat (3) press(0, 1);
        press(1, 0);
        press(0, 1);
        press(1, 0);
        repeat (2) press(0, 1);
        press(1, 0);
        cyc(12);
        chk("t2_nloads", lg_kind.size(), 3);
        if (lg_kind.size() == 3) begin
            chk("t2_kind_h", lg_kind[0], 1);
            chk("t2_kind_m", lg_kind[1], 2);
            chk("t2_kind_s", lg_kind[2], 3);
            chk("t2_hour", lg_data[0], 1);
            chk("t2_min", lg_data[1], 0);
            chk("t2_sec", lg_data[2], 12);
            chk("t2_consec", lg_cyc[2] - lg_cyc[0], 2);
            n_set = 0;
            first = -1;
            foreach (tick_q[i]) begin
                if (tick_q[i] <= lg_cyc[2]) n_set++;
                else if (first < 0) first = tick_q[i];
            end
            chk("t5_no_tick_set", n_set, 0);
            chk("t5_tick_lat", first - lg_cyc[2], 8);
        end

        // mode and inc together in SET_MIN: mode wins
        set_in(5, 30, 7);
        clr_logs();
        press(1, 0);
        press(1, 0);
        chk("t3_ef_min", bus.edit_field, 2);
        press(1, 1);
        chk("t3_ef_sec", bus.edit_field, 3);
        press(1, 0);
        cyc(3);
        chk("t3_nloads", lg_data.size(), 3);
        if (lg_data.size() == 3) begin
            chk("t3_hour", lg_data[0], 5);
            chk("t3_min", lg_data[1], 30);
            chk("t3_sec", lg_data[2], 7);
        end

        // reset arriving right after the hour load aborts the commit
        set_in(1, 2, 3);
        clr_logs();
        repeat (3) press(1, 0);
        bus.btn_mode = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc(1);
            seen = bus.load_hour;
        end
        bus.btn_mode = 1'b0;
        chk("t4_saw_load_hour", seen, 1);
        clear_n = 1'b0;
        #1;
        chk("t4_async_zero", {bus.sec_tick, bus.load_hour, bus.load_min,
            bus.load_sec, bus.load_data, bus.edit_field, bus.blink}, 0);
        check_all();
        cyc(2);
        clear_n = 1'b1;
        cyc(10);
        chk("t4_only_hour_load", lg_kind.size(), 1);

        // held increment in SET_SEC from 0
        set_in(0, 0, 0);
        clr_logs();
        repeat (3) press(1, 0);
        bus.btn_inc = 1'b1;
        cyc(40);
        bus.btn_inc = 1'b0;
        cyc(5);
        press(1, 0);
        cyc(3);
        chk("t6_nloads", lg_data.size(), 3);
        if (lg_data.size() == 3) begin
`ifdef AUTO_REPEAT_EN
            chk("t6_sec_hold", lg_data[2], 6);
`else
            chk("t6_sec_hold", lg_data[2], 1);
`endif
        end

        // random buttons, counter values and occasional reset
        for (int i = 0; i < 3000; i++) begin
            bus.btn_mode = ($urandom % 8 == 0);
            bus.btn_inc = ($urandom % 3 == 0);
            if ($urandom % 16 == 0) begin
                set_in($urandom % 24, $urandom % 60, $urandom % 60);
            end
            clear_n = ($urandom % 700 != 0);
            cyc(1);
        end
        clear_n = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
